// File: rtl/reg_scoreboard_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | reg_scoreboard_pkg: register map ids, tag type and scoreboard transactions |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package reg_scoreboard_pkg;

   localparam int REG_CNT  = 18;
   localparam int REG_ID_W = 8;
   localparam int TAG_W    = 4;

   typedef logic [TAG_W-1:0] tag_t;

   typedef enum logic [REG_ID_W-1:0] {
      REG_RAX, REG_RCX, REG_RDX, REG_RBX, REG_RSP, REG_RBP, REG_RSI, REG_RDI,
      REG_R8,  REG_R9,  REG_R10, REG_R11, REG_R12, REG_R13, REG_R14, REG_R15,
      REG_RFLAGS, REG_RH0
   } reg_id_t;

   typedef struct packed {
      logic                src0_vld;
      logic [REG_ID_W-1:0] src0;
      logic                src1_vld;
      logic [REG_ID_W-1:0] src1;
      logic                dst_vld;
      logic [REG_ID_W-1:0] dst;
   } sb_iss_t;

   typedef struct packed {
      logic                dst_vld;
      logic [REG_ID_W-1:0] dst;
      tag_t                tag;
   } sb_wb_t;

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard_tag_ring.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | reg_tag_ring: issue/retire tag counters and in-flight occupancy            |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module reg_tag_ring #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             accept,
   input  logic             retire,
   input  logic [TAG_W-1:0] wb_tag,
   output logic [TAG_W-1:0] next_tag,
   output logic [TAG_W:0]   inflight,
   output logic             full
);

   localparam logic [TAG_W:0] DEPTH = {1'b1, {TAG_W{1'b0}}};

   logic [TAG_W-1:0] oldest_tag;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         next_tag   <= '0;
         oldest_tag <= '0;
         inflight   <= '0;
      end else if (flush) begin
         next_tag   <= '0;
         oldest_tag <= '0;
         inflight   <= '0;
      end else begin
         if (accept) next_tag <= next_tag + TAG_W'(1);
         if (retire) oldest_tag <= oldest_tag + TAG_W'(1);
         case ({accept, retire})
            2'b10:   inflight <= inflight + (TAG_W+1)'(1);
            2'b01:   inflight <= inflight - (TAG_W+1)'(1);
            default: ;
         endcase
      end
   end

   assign full = (inflight == DEPTH);

   // Writeback must be in order and only while something is outstanding.
   a_wb_nonempty: assert property (@(posedge clk) disable iff (!reset_n)
      retire |-> (inflight != '0));
   a_wb_in_order: assert property (@(posedge clk) disable iff (!reset_n)
      retire |-> (wb_tag == oldest_tag));

endmodule
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | reg_scoreboard: RAW hazard stall and writeback-tag allocation per register |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int REG_CNT = reg_scoreboard_pkg::REG_CNT,
   parameter int TAG_W   = reg_scoreboard_pkg::TAG_W
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                flush,
   input  logic                iss_valid,
   output logic                iss_ready,
   input  logic                iss_src0_vld,
   input  logic [REG_ID_W-1:0] iss_src0,
   input  logic                iss_src1_vld,
   input  logic [REG_ID_W-1:0] iss_src1,
   input  logic                iss_dst_vld,
   input  logic [REG_ID_W-1:0] iss_dst,
   output logic [TAG_W-1:0]    iss_tag,
   input  logic                wb_valid,
   input  logic [TAG_W-1:0]    wb_tag,
   input  logic                wb_dst_vld,
   input  logic [REG_ID_W-1:0] wb_dst,
   output logic [REG_CNT-1:0]  busy_vec,
   output logic [TAG_W:0]      inflight
);

   localparam logic [REG_ID_W-1:0] REG_LIMIT = REG_ID_W'(REG_CNT);

   sb_iss_t            iss;
   logic [REG_CNT-1:0] busy;
   logic [TAG_W-1:0]   owner [REG_CNT];
   logic [REG_CNT-1:0] wb_hit;
   logic [REG_CNT-1:0] eff_busy;
   logic [TAG_W-1:0]   next_tag;
   logic               full;
   logic               accept;
   logic               retire;
   logic               src0_hazard;
   logic               src1_hazard;

   assign iss = '{src0_vld: iss_src0_vld, src0: iss_src0,
                  src1_vld: iss_src1_vld, src1: iss_src1,
                  dst_vld:  iss_dst_vld,  dst:  iss_dst};

   // A retiring op only releases a register it still owns (stale writers do not).
   always_comb begin
      wb_hit = '0;
      for (int r = 0; r < REG_CNT; r++) begin
         wb_hit[r] = wb_valid & wb_dst_vld & (wb_dst == REG_ID_W'(r)) & (wb_tag == owner[r]);
      end
   end

   assign eff_busy = busy & ~wb_hit;

   // Ids at or above REG_CNT never match a slot, so they read as not busy.
   always_comb begin
      src0_hazard = 1'b0;
      src1_hazard = 1'b0;
      for (int r = 0; r < REG_CNT; r++) begin
         if (iss.src0_vld && iss.src0 == REG_ID_W'(r) && eff_busy[r]) src0_hazard = 1'b1;
         if (iss.src1_vld && iss.src1 == REG_ID_W'(r) && eff_busy[r]) src1_hazard = 1'b1;
      end
   end

   assign iss_ready = reset_n & ~flush & ~full & ~src0_hazard & ~src1_hazard;
   assign accept    = iss_valid & iss_ready;
   assign retire    = wb_valid & ~flush;
   assign iss_tag   = next_tag;
   assign busy_vec  = busy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy <= '0;
         for (int r = 0; r < REG_CNT; r++) owner[r] <= '0;
      end else if (flush) begin
         busy <= '0;
         for (int r = 0; r < REG_CNT; r++) owner[r] <= '0;
      end else begin
         for (int r = 0; r < REG_CNT; r++) begin
            // A new writer takes precedence over a same-cycle release.
            if (accept && iss.dst_vld && iss.dst == REG_ID_W'(r)) begin
               busy[r]  <= 1'b1;
               owner[r] <= next_tag;
            end else if (wb_hit[r]) begin
               busy[r] <= 1'b0;
            end
         end
      end
   end

   reg_tag_ring #(
      .TAG_W (TAG_W)
   ) u_tag_ring (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (flush),
      .accept   (accept),
      .retire   (retire),
      .wb_tag   (wb_tag),
      .next_tag (next_tag),
      .inflight (inflight),
      .full     (full)
   );

   a_src0_range: assert property (@(posedge clk) disable iff (!reset_n || flush)
      (iss_valid && iss_src0_vld) |-> (iss_src0 < REG_LIMIT));
   a_src1_range: assert property (@(posedge clk) disable iff (!reset_n || flush)
      (iss_valid && iss_src1_vld) |-> (iss_src1 < REG_LIMIT));
   a_dst_range: assert property (@(posedge clk) disable iff (!reset_n || flush)
      (iss_valid && iss_dst_vld) |-> (iss_dst < REG_LIMIT));
   a_wb_range: assert property (@(posedge clk) disable iff (!reset_n || flush)
      (wb_valid && wb_dst_vld) |-> (wb_dst < REG_LIMIT));

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_reg_scoreboard: directed stimulus with a writeback-order scoreboard     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_reg_scoreboard;
   import reg_scoreboard_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        iss_valid;
   logic        iss_ready;
   logic        iss_src0_vld;
   logic [7:0]  iss_src0;
   logic        iss_src1_vld;
   logic [7:0]  iss_src1;
   logic        iss_dst_vld;
   logic [7:0]  iss_dst;
   logic [3:0]  iss_tag;
   logic        wb_valid;
   logic [3:0]  wb_tag;
   logic        wb_dst_vld;
   logic [7:0]  wb_dst;
   logic [17:0] busy_vec;
   logic [4:0]  inflight;

   typedef struct {
      logic [3:0] tag;
      logic       dst_vld;
      logic [7:0] dst;
   } wb_item_t;

   wb_item_t wb_q[$];
   int       exp_tag;
   int       checks;
   int       errors;

   always #5 clk = ~clk;

   reg_scoreboard dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .flush        (flush),
      .iss_valid    (iss_valid),
      .iss_ready    (iss_ready),
      .iss_src0_vld (iss_src0_vld),
      .iss_src0     (iss_src0),
      .iss_src1_vld (iss_src1_vld),
      .iss_src1     (iss_src1),
      .iss_dst_vld  (iss_dst_vld),
      .iss_dst      (iss_dst),
      .iss_tag      (iss_tag),
      .wb_valid     (wb_valid),
      .wb_tag       (wb_tag),
      .wb_dst_vld   (wb_dst_vld),
      .wb_dst       (wb_dst),
      .busy_vec     (busy_vec),
      .inflight     (inflight)
   );

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Registered state: busy bits as given, occupancy equals outstanding scoreboard entries.
   task automatic chk_state(input string name, input logic [17:0] exp_busy);
      chk({name, "_busy"}, {14'd0, busy_vec}, {14'd0, exp_busy});
      chk({name, "_inflight"}, {27'd0, inflight}, wb_q.size());
   endtask

   task automatic tick();
      @(negedge clk);
      flush        = 1'b0;
      iss_valid    = 1'b0;
      iss_src0_vld = 1'b0;
      iss_src0     = '0;
      iss_src1_vld = 1'b0;
      iss_src1     = '0;
      iss_dst_vld  = 1'b0;
      iss_dst      = '0;
      wb_valid     = 1'b0;
      wb_tag       = '0;
      wb_dst_vld   = 1'b0;
      wb_dst       = '0;
   endtask

   task automatic offer(input logic s0v, input logic [7:0] s0, input logic s1v,
                        input logic [7:0] s1, input logic dv, input logic [7:0] d);
      iss_valid    = 1'b1;
      iss_src0_vld = s0v;
      iss_src0     = s0;
      iss_src1_vld = s1v;
      iss_src1     = s1;
      iss_dst_vld  = dv;
      iss_dst      = d;
   endtask

   task automatic expect_accept(input string name);
      #1;
      chk({name, "_ready"}, {31'd0, iss_ready}, 1);
      chk({name, "_tag"}, {28'd0, iss_tag}, exp_tag);
      wb_q.push_back('{tag: 4'(exp_tag), dst_vld: iss_dst_vld, dst: iss_dst});
      exp_tag = (exp_tag + 1) % 16;
   endtask

   task automatic retire_next();
      wb_item_t it;
      if (wb_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL wb_queue observed=empty expected=entry");
      end else begin
         it         = wb_q.pop_front();
         wb_valid   = 1'b1;
         wb_tag     = it.tag;
         wb_dst_vld = it.dst_vld;
         wb_dst     = it.dst;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks  = 0;
      errors  = 0;
      exp_tag = 0;
      reset_n = 1'b0;
      tick();
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, iss_ready}, 0);
      chk("rst_tag", {28'd0, iss_tag}, 0);
      chk_state("rst", 18'h0);
      reset_n = 1'b1;

      // Single writer of rax
      offer(0, 0, 0, 0, 1, REG_RAX); expect_accept("rax_iss"); tick();
      chk_state("rax_after_iss", 18'h00001);
      retire_next(); tick();
      chk_state("rax_after_wb", 18'h0);

      // RAW on src0 with same-cycle writeback bypass
      offer(0, 0, 0, 0, 1, REG_RCX); expect_accept("rcx_iss"); tick();
      offer(1, REG_RCX, 0, 0, 0, 0);
      #1 chk("rcx_stall", {31'd0, iss_ready}, 0);
      retire_next(); expect_accept("rcx_bypass"); tick();
      chk_state("rcx_after", 18'h0);

      // RAW on src1; retiring an unrelated op does not release it
      offer(0, 0, 0, 0, 1, REG_RBX); expect_accept("rbx_iss"); tick();
      retire_next(); offer(0, 0, 1, REG_RBX, 0, 0);
      #1 chk("rbx_src1_stall", {31'd0, iss_ready}, 0);
      tick();
      chk_state("rbx_pending", 18'h00008);
      retire_next(); offer(0, 0, 1, REG_RBX, 0, 0); expect_accept("rbx_bypass"); tick();
      retire_next(); tick();
      chk_state("rbx_drained", 18'h0);

      // Two writers of rdx: only the youngest releases it
      flush = 1'b1; tick(); wb_q.delete(); exp_tag = 0;
      chk("flush_tag", {28'd0, iss_tag}, 0);
      chk_state("flush", 18'h0);
      offer(0, 0, 0, 0, 1, REG_RDX); expect_accept("rdx_w0"); tick();
      offer(0, 0, 0, 0, 1, REG_RDX); expect_accept("rdx_w1"); tick();
      chk_state("rdx_two", 18'h00004);
      retire_next(); tick();
      chk_state("rdx_stale_wb", 18'h00004);
      retire_next(); tick();
      chk_state("rdx_owner_wb", 18'h0);

      // Fill all 16 tags, stall on full, wrap to tag 0
      flush = 1'b1; tick(); wb_q.delete(); exp_tag = 0;
      for (int i = 0; i < 16; i++) begin
         offer(0, 0, 0, 0, 0, 0); expect_accept($sformatf("fill%0d", i)); tick();
      end
      chk_state("full", 18'h0);
      offer(0, 0, 0, 0, 0, 0);
      #1 chk("full_stall", {31'd0, iss_ready}, 0);
      retire_next();
      #1 chk("full_stall_wb", {31'd0, iss_ready}, 0);
      tick();
      offer(0, 0, 0, 0, 0, 0);
      #1 chk("wrap_tag0", {28'd0, iss_tag}, 0);
      expect_accept("wrap_iss"); tick();
      for (int i = 0; i < 16; i++) begin
         retire_next(); tick();
      end
      chk_state("drained", 18'h0);

      // Same-cycle writeback and reissue of rflags: set wins, owner moves
      offer(0, 0, 0, 0, 1, REG_RFLAGS); expect_accept("rfl_iss"); tick();
      retire_next(); offer(0, 0, 0, 0, 1, REG_RFLAGS); expect_accept("rfl_reissue"); tick();
      chk_state("rfl_set_wins", 18'h10000);
      retire_next(); tick();
      chk_state("rfl_new_owner_wb", 18'h0);

      // Flush with five in flight and a concurrent writeback
      for (int i = 0; i < 5; i++) begin
         offer(0, 0, 0, 0, 1, 8'(8 + i)); expect_accept($sformatf("r%0d_iss", 8 + i)); tick();
      end
      chk_state("five", 18'h01F00);
      flush = 1'b1; retire_next(); offer(0, 0, 0, 0, 1, REG_RAX);
      #1 chk("flush_ready", {31'd0, iss_ready}, 0);
      tick(); wb_q.delete(); exp_tag = 0;
      chk("flush5_tag", {28'd0, iss_tag}, 0);
      chk_state("flush5", 18'h0);

      // Asynchronous reset in the middle of an issue
      offer(0, 0, 0, 0, 1, REG_RAX); expect_accept("pre_rst_iss"); tick();
      chk_state("pre_rst", 18'h00001);
      offer(0, 0, 0, 0, 1, REG_RCX);
      #2 reset_n = 1'b0;
      #1;
      wb_q.delete();
      chk("midrst_ready", {31'd0, iss_ready}, 0);
      chk("midrst_tag", {28'd0, iss_tag}, 0);
      chk_state("midrst", 18'h0);
      tick();
      reset_n = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
